lsu_mem_port: RTL and testbench

- Load/store initiator that drives the byte-lane data RAM on behalf of the pipeline's memory stage.
- Accepts one RV32I load or store request per handshake and generates byte enables and lane-replicated write data for stores.
- For loads, issues the synchronous read, then extracts and sign- or zero-extends the returned lane and returns it with the destination register tag.
- Flags misaligned, out-of-range and illegal-width requests without touching RAM.

---
 rtl/lsu_mem_port.sv | 180 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// RV32I load/store port in front of a byte-lane synchronous data RAM.
// Stores complete in the accept cycle; loads return extended data two cycles after accept.
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        fault_o,
    output logic [3:0]  ram_w_en,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_data,
    output logic        ram_r_en,
    output logic [31:0] ram_r_addr,
    input  logic [31:0] ram_r_data
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_LD_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [4:0]  resp_rd_q;
    logic        fault_q;

    logic        accept_s;
    logic        legal_s;
    logic        st_go_s;
    logic        ld_go_s;

    function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (addr[0] == 1'b0);
            3'b010:  ok = (addr[1:0] == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && (addr[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok && (addr < MEM_BYTES);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b0001 << off;
            3'b001:  m = 4'b0011 << {off[1], 1'b0};
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Lane select plus sign/zero extension of the returned RAM word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Handshake qualification; ready is forced low while reset is held.
    always_comb begin
        req_ready = rst && (state_q == ST_IDLE);
        accept_s  = req_valid && req_ready;
        legal_s   = req_legal(req_we, req_funct3, req_addr);
        st_go_s   = accept_s && legal_s && req_we;
        ld_go_s   = accept_s && legal_s && !req_we;
    end

    // RAM-side request signals, combinational in the accept cycle.
    always_comb begin
        ram_w_addr = req_addr;
        ram_w_data = store_data(req_funct3, req_wdata);
        ram_r_addr = req_addr;
        if (st_go_s) begin
            ram_w_en = store_mask(req_funct3, req_addr[1:0]);
        end else begin
            ram_w_en = 4'b0000;
        end
        if (ld_go_s) begin
            ram_r_en = 1'b1;
        end else begin
            ram_r_en = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_go_s) begin
                    state_d = ST_LD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LD_WAIT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, captured load context and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_rd_q    <= 5'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_q      <= accept_s && !legal_s;
            resp_valid_q <= (state_q == ST_LD_WAIT);
            if (ld_go_s) begin
                off_q    <= req_addr[1:0];
                funct3_q <= req_funct3;
                rd_q     <= req_rd;
            end else begin
                off_q    <= off_q;
                funct3_q <= funct3_q;
                rd_q     <= rd_q;
            end
            if (state_q == ST_LD_WAIT) begin
                resp_rdata_q <= load_extend(funct3_q, off_q, ram_r_data);
                resp_rd_q    <= rd_q;
            end else begin
                resp_rdata_q <= resp_rdata_q;
                resp_rd_q    <= resp_rd_q;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign fault_o    = fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a byte-level memory model predicts every
// per-cycle output, and a negedge process compares the DUT against it.
module tb_lsu_mem_port;
    localparam int MEMB = 16384;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        fault_o;
    logic [3:0]  ram_w_en;
    logic [31:0] ram_w_addr;
    logic [31:0] ram_w_data;
    logic        ram_r_en;
    logic [31:0] ram_r_addr;
    logic [31:0] ram_r_data = 32'd0;

    lsu_mem_port #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd), .fault_o(fault_o),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;

    // Environment RAM driven by the DUT's RAM port.
    logic [7:0] env_mem [0:MEMB-1];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_w_en[i]) env_mem[{ram_w_addr[13:2], 2'b00} + i] <= ram_w_data[8*i +: 8];
        if (ram_r_en)
            ram_r_data <= {env_mem[{ram_r_addr[13:2], 2'b11}], env_mem[{ram_r_addr[13:2], 2'b10}],
                           env_mem[{ram_r_addr[13:2], 2'b01}], env_mem[{ram_r_addr[13:2], 2'b00}]};
    end

    // Reference model state and per-cycle expectations.
    logic [7:0]  ref_mem [0:MEMB-1];
    logic        exp_rv    [MAXC];
    logic [31:0] exp_rdata [MAXC];
    logic [4:0]  exp_rd    [MAXC];
    logic        exp_f     [MAXC];
    logic [3:0]  exp_wen   [MAXC];
    logic [31:0] exp_wdata [MAXC];
    logic [31:0] exp_waddr [MAXC];
    logic        exp_ren   [MAXC];
    logic [31:0] exp_raddr [MAXC];
    logic        ld_acc    [MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int fsize(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (we && f3[2]) return 1'b0;
        if ((addr % fsize(f3)) != 0) return 1'b0;
        if (addr >= MEMB) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v;
        int sz;
        sz = fsize(f3);
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(ref_mem[addr + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic model_ready(input int c);
        return rst && !(c > 0 && ld_acc[c-1]);
    endfunction

    task automatic model_accept(input int c, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        int sz;
        logic [31:0] d;
        sz = fsize(f3);
        if (!model_legal(we, f3, addr)) begin
            exp_f[c+1] = 1'b1;
        end else if (we) begin
            for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % sz) +: 8];
            exp_wen[c]   = 4'(((1 << sz) - 1) << (addr % 4));
            exp_wdata[c] = d;
            exp_waddr[c] = addr;
            for (int i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
        end else begin
            exp_ren[c]     = 1'b1;
            exp_raddr[c]   = addr;
            ld_acc[c]      = 1'b1;
            exp_rv[c+2]    = 1'b1;
            exp_rd[c+2]    = rd;
            exp_rdata[c+2] = model_load(f3, addr);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output int acc_c);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        while (!model_ready(cyc)) begin
            waited++;
            if (waited > 8) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        acc_c = cyc;
        model_accept(cyc, we, f3, addr, wd, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_rv[i] = 1'b0; exp_f[i] = 1'b0; exp_wen[i] = 4'd0;
            exp_ren[i] = 1'b0; ld_acc[i] = 1'b0;
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c >= 1 && c < MAXC - 2) begin
            chk("req_ready", req_ready, model_ready(c));
            chk("resp_valid", resp_valid, exp_rv[c]);
            chk("fault_o", fault_o, exp_f[c]);
            chk("ram_w_en", ram_w_en, exp_wen[c]);
            chk("ram_r_en", ram_r_en, exp_ren[c]);
            if (exp_rv[c]) begin
                chk("resp_rdata", resp_rdata, exp_rdata[c]);
                chk("resp_rd", resp_rd, exp_rd[c]);
            end
            if (exp_wen[c] != 4'd0) begin
                chk("ram_w_addr", ram_w_addr, exp_waddr[c]);
                chk("ram_w_data", ram_w_data, exp_wdata[c]);
            end
            if (exp_ren[c]) chk("ram_r_addr", ram_r_addr, exp_raddr[c]);
            if (!rst) begin
                chk("rst_resp_rdata", resp_rdata, 32'd0);
                chk("rst_resp_rd", resp_rd, 32'd0);
            end
        end
    end

    initial begin
        int c, c1, c2, c3;
        clear_from(0);
        for (int i = 0; i < MAXC; i++) begin
            exp_rdata[i] = 32'd0; exp_rd[i] = 5'd0; exp_wdata[i] = 32'd0;
            exp_waddr[i] = 32'd0; exp_raddr[i] = 32'd0;
        end
        for (int i = 0; i < MEMB; i++) begin
            env_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        {env_mem[259], env_mem[258], env_mem[257], env_mem[256]} = 32'h8001FF7F;
        {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'h8001FF7F;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        // Sign/zero-extending loads from word 0x8001FF7F at 0x100.
        issue(1'b0, 3'b000, 32'h101, 32'd0, 5'd7, c);
        chk("pin_lb", exp_rdata[c+2], 32'hFFFFFFFF);
        chk("pin_lb_rd", 32'(exp_rd[c+2]), 32'd7);
        issue(1'b0, 3'b100, 32'h100, 32'd0, 5'd8, c);
        chk("pin_lbu", exp_rdata[c+2], 32'h0000007F);
        issue(1'b0, 3'b001, 32'h102, 32'd0, 5'd9, c);
        chk("pin_lh", exp_rdata[c+2], 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'h102, 32'd0, 5'd10, c);
        chk("pin_lhu", exp_rdata[c+2], 32'h00008001);
        idle(3);

        // SB 0xA5 to 0x103.
        issue(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, c);
        chk("pin_sb_en", 32'(exp_wen[c]), 32'h8);
        chk("pin_sb_data", exp_wdata[c], 32'hA5A5A5A5);
        idle(2);

        // Continuous LW, LW, SW.
        issue(1'b0, 3'b010, 32'h200, 32'd0, 5'd1, c1);
        issue(1'b0, 3'b010, 32'h100, 32'd0, 5'd2, c2);
        issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5'd0, c3);
        chk("pin_b2b_2nd", 32'(c2 - c1), 32'd2);
        chk("pin_b2b_3rd", 32'(c3 - c1), 32'd4);
        chk("pin_lw_word", exp_rdata[c2+2], 32'hA501FF7F);
        idle(3);

        // Store then read back through the RAM.
        issue(1'b1, 3'b001, 32'h306, 32'h1234BEEF, 5'd0, c);
        issue(1'b0, 3'b010, 32'h304, 32'd0, 5'd4, c);
        issue(1'b0, 3'b001, 32'h306, 32'd0, 5'd5, c);
        chk("pin_lh_readback", exp_rdata[c+2], 32'hFFFFBEEF);
        idle(3);

        // Faults: misalignment, range, illegal widths.
        issue(1'b0, 3'b010, 32'h102, 32'd0, 5'd3, c);
        chk("pin_fault_lw", 32'(exp_f[c+1]), 32'd1);
        issue(1'b1, 3'b001, 32'h201, 32'h5555, 5'd0, c);
        issue(1'b0, 3'b010, 32'h4000, 32'd0, 5'd3, c);
        issue(1'b0, 3'b000, 32'h3FFF, 32'd0, 5'd11, c);
        issue(1'b1, 3'b100, 32'h200, 32'h77, 5'd0, c);
        issue(1'b0, 3'b011, 32'h200, 32'd0, 5'd3, c);
        idle(3);

        // Reset while a load is in flight.
        issue(1'b0, 3'b010, 32'h100, 32'd0, 5'd6, c);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        clear_from(cyc);
        idle(2);
        rst = 1'b1;
        idle(2);
        issue(1'b0, 3'b000, 32'h103, 32'd0, 5'd12, c);
        chk("pin_post_rst_lb", exp_rdata[c+2], 32'hFFFFFFA5);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
